// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load, with a saturating fill count.
// Latency: one clock from the sampling edge to q; qb, serial outputs and full are combinational from q and fill_cnt.
// Backpressure: none; en holds the whole state, sclr clears it and takes priority over en.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         sclr,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_msb,
  input  logic                         sin_lsb,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             qb,
  output logic                         sout_lsb,
  output logic                         sout_msb,
  output logic [$clog2(WIDTH+1)-1:0]   fill_cnt,
  output logic                         full
);

  localparam int CW = $clog2(WIDTH + 1);

  // The fill counter saturates at WIDTH, i.e. "every bit of q came from a shift".
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_next_q;
  logic [CW-1:0]    w_next_cnt;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

  // Both shift directions share one counter; direction changes keep counting.
  assign w_cnt_inc = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CW'(1);
  assign w_shr     = {sin_msb, r_q[WIDTH-1:1]};
  assign w_shl     = {r_q[WIDTH-2:0], sin_lsb};

  // Next-state selection: sclr beats en, en low freezes everything, then mode decides.
  always_comb begin
    w_next_q   = r_q;
    w_next_cnt = r_cnt;
    if (sclr) begin
      w_next_q   = RESET_VAL;
      w_next_cnt = '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_next_q   = r_q;
          w_next_cnt = r_cnt;
        end
        MODE_SHR: begin
          w_next_q   = w_shr;
          w_next_cnt = w_cnt_inc;
        end
        MODE_SHL: begin
          w_next_q   = w_shl;
          w_next_cnt = w_cnt_inc;
        end
        MODE_LOAD: begin
          w_next_q   = d;
          w_next_cnt = CNT_FULL;
        end
        default: begin
          w_next_q   = r_q;
          w_next_cnt = r_cnt;
        end
      endcase
    end
  end

  // State registers; the async reset also throws away any partial fill count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= RESET_VAL;
      r_cnt <= '0;
    end else begin
      r_q   <= w_next_q;
      r_cnt <= w_next_cnt;
    end
  end

  // Outputs come straight off the registers so a downstream instance sees the
  // pre-edge shifted-out bit and cascades chain without a bubble.
  assign q        = r_q;
  assign qb       = ~r_q;
  assign sout_lsb = r_q[0];
  assign sout_msb = r_q[WIDTH-1];
  assign fill_cnt = r_cnt;
  assign full     = (r_cnt == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk;
  logic       reset;
  logic       en;
  logic       sclr;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_msb;
  logic       sin_lsb;

  logic [7:0] q, qb;
  logic       sout_lsb, sout_msb, full;
  logic [3:0] fill_cnt;

  logic [7:0] hq, hqb, lq, lqb;
  logic       h_sl, h_sm, h_full, l_sl, l_sm, l_full;
  logic [3:0] h_cnt, l_cnt;

  logic [7:0] rq, rqb;
  logic       r_sl, r_sm, r_full;
  logic [3:0] r_cnt;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q), .qb(qb),
    .sout_lsb(sout_lsb), .sout_msb(sout_msb), .fill_cnt(fill_cnt), .full(full)
  );

  // Upper stage of the cascade: fed serially by the bench.
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_hi (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(hq), .qb(hqb),
    .sout_lsb(h_sl), .sout_msb(h_sm), .fill_cnt(h_cnt), .full(h_full)
  );

  // Lower stage of the cascade: fed from the upper stage's shifted-out bit.
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_lo (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d),
    .sin_msb(h_sl), .sin_lsb(sin_lsb), .q(lq), .qb(lqb),
    .sout_lsb(l_sl), .sout_msb(l_sm), .fill_cnt(l_cnt), .full(l_full)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) u_rv (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(rq), .qb(rqb),
    .sout_lsb(r_sl), .sout_msb(r_sm), .fill_cnt(r_cnt), .full(r_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_Q = 0, K_QB = 1, K_FILL = 2, K_FULL = 3, K_SOL = 4,
                 K_SOM = 5, K_CAS = 6, K_RVQ = 7, K_RVQB = 8;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  event ev_chk;
  int   total = 0;
  int   bad   = 0;

  // Monitor: pops every queued expectation and compares it with the DUT now.
  initial begin
    forever begin
      @(ev_chk);
      while (sb.size() > 0) begin
        chk_t        c;
        logic [15:0] act;
        c = sb.pop_front();
        case (c.kind)
          K_Q:     act = {8'h00, q};
          K_QB:    act = {8'h00, qb};
          K_FILL:  act = {12'h000, fill_cnt};
          K_FULL:  act = {15'h0000, full};
          K_SOL:   act = {15'h0000, sout_lsb};
          K_SOM:   act = {15'h0000, sout_msb};
          K_CAS:   act = {hq, lq};
          K_RVQ:   act = {8'h00, rq};
          K_RVQB:  act = {8'h00, rqb};
          default: act = 16'hxxxx;
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [15:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  // Queue the full expected state of the main DUT and hand it to the monitor.
  task automatic expect_core(input logic [7:0] eq, input logic [3:0] ef, input string name);
    push(K_Q,    {8'h00, eq},  {name, ".q"});
    push(K_QB,   {8'h00, ~eq}, {name, ".qb"});
    push(K_FILL, {12'h000, ef}, {name, ".fill"});
    push(K_FULL, {15'h0000, (ef == 4'd8)}, {name, ".full"});
    -> ev_chk;
    #1;
  endtask

  task automatic step(input logic e, input logic s, input logic [1:0] m, input logic [7:0] dd,
                      input logic sm, input logic sl);
    @(negedge clk);
    en = e; sclr = s; mode = m; d = dd; sin_msb = sm; sin_lsb = sl;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges with busy-looking inputs; they must be ignored.
  task automatic rst_pulse(input string name);
    @(negedge clk);
    en = 1'b1; sclr = 1'b0; mode = 2'b11; d = 8'hFF;
    #2 reset = 1'b0;
    #1;
    push(K_RVQ,  16'h003C, {name, ".rv_q"});
    push(K_RVQB, 16'h00C3, {name, ".rv_qb"});
    expect_core(8'h00, 4'd0, name);
    @(posedge clk);
    #1;
    expect_core(8'h00, 4'd0, {name, "_hold"});
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0; mode = 2'b00;
  endtask

  initial begin
    logic [15:0] pat;
    reset = 1'b1; en = 1'b0; sclr = 1'b0; mode = 2'b00; d = 8'h00;
    sin_msb = 1'b0; sin_lsb = 1'b0;

    rst_pulse("rst0");

    // Load then right shift; the pre-edge serial outputs reflect A5.
    step(1, 0, 2'b11, 8'hA5, 0, 0);
    expect_core(8'hA5, 4'd8, "load_a5");
    @(negedge clk);
    mode = 2'b01; sin_msb = 1'b1;
    #1;
    push(K_SOL, 16'h0001, "pre_shr.sout_lsb");
    push(K_SOM, 16'h0001, "pre_shr.sout_msb");
    -> ev_chk;
    #1;
    @(posedge clk);
    #1;
    expect_core(8'hD2, 4'd8, "shr_d2");

    // Partial fill, then an async reset must discard it.
    rst_pulse("rst1");
    for (int i = 1; i <= 3; i++) step(1, 0, 2'b10, 8'h00, 0, 1);
    expect_core(8'h07, 4'd3, "part_fill");
    rst_pulse("rst_mid");

    // Nine left shifts of ones: count saturates at 8, full stays high.
    for (int k = 1; k <= 9; k++) begin
      logic [8:0] ones;
      step(1, 0, 2'b10, 8'h00, 0, 1);
      ones = (9'd1 << ((k > 8) ? 8 : k)) - 9'd1;
      expect_core(ones[7:0], (k > 8) ? 4'd8 : 4'(k), $sformatf("shl_%0d", k));
    end

    // Clear, then a direction change keeps counting; hold mode freezes.
    step(1, 1, 2'b10, 8'h00, 0, 0);
    expect_core(8'h00, 4'd0, "sclr0");
    step(1, 0, 2'b01, 8'h00, 1, 0);
    expect_core(8'h80, 4'd1, "dir_shr");
    step(1, 0, 2'b10, 8'h00, 0, 1);
    expect_core(8'h01, 4'd2, "dir_shl");
    step(1, 0, 2'b00, 8'hFF, 1, 1);
    expect_core(8'h01, 4'd2, "hold_mode");

    // sclr beats a load in the same cycle; then en low ignores loads.
    step(1, 0, 2'b11, 8'hA5, 0, 0);
    expect_core(8'hA5, 4'd8, "load_a5b");
    step(1, 1, 2'b11, 8'h3C, 0, 0);
    push(K_RVQ,  16'h003C, "sclr.rv_q");
    push(K_RVQB, 16'h00C3, "sclr.rv_qb");
    expect_core(8'h00, 4'd0, "sclr_vs_load");
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 2'b11, 8'h3C, 0, 0);
      expect_core(8'h00, 4'd0, $sformatf("en_low_%0d", k));
    end

    // en low freezes a loaded value against shifts; sclr still wins with en low.
    step(1, 0, 2'b11, 8'h5A, 0, 0);
    expect_core(8'h5A, 4'd8, "load_5a");
    step(0, 0, 2'b01, 8'h00, 1, 1);
    expect_core(8'h5A, 4'd8, "en_low_shr");
    step(0, 1, 2'b01, 8'h00, 1, 1);
    expect_core(8'h00, 4'd0, "sclr_en_low");

    // Cascade: 16 right shifts; first bit in ends at the lowest position.
    rst_pulse("rst_cas");
    pat = 16'hC3A5;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 2'b01, 8'h00, pat[i], 0);
      if (i == 7) begin
        push(K_CAS, {pat[7:0], 8'h00}, "cascade_8");
        -> ev_chk;
        #1;
      end
    end
    push(K_CAS, pat, "cascade_16");
    -> ev_chk;
    #1;

    // Nothing may be left unchecked in the scoreboard.
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, 8, register width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter RESET_VAL, 0, value loaded into q by reset and by sclr; it is WIDTH bits wide.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  clock enable for shift, load and hold operations.
REQ-006 sclr  input  1  synchronous clear, active-high.
REQ-007 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_msb  input  1  serial input entering bit WIDTH-1 on a right shift.
REQ-010 sin_lsb  input  1  serial input entering bit 0 on a left shift.
REQ-011 q  output  WIDTH  register contents.
REQ-012 qb  output  WIDTH  bitwise complement of q.
REQ-013 sout_lsb  output  1  equals q[0].
REQ-014 sout_msb  output  1  equals q[WIDTH-1].
REQ-015 fill_cnt  output  $clog2(WIDTH+1)  count of valid bits shifted in since the last load or clear.
REQ-016 full  output  1  high when fill_cnt == WIDTH.

Function
REQ-017 Priority SHALL be: reset (async) > sclr > en low > mode.
REQ-018 sclr=1 at an edge SHALL set q=RESET_VAL and fill_cnt=0, regardless of en, mode and d.
REQ-019 en=0 with sclr=0 SHALL hold q and fill_cnt unchanged, whatever the value of mode.
REQ-020 mode=00 (hold) SHALL leave q and fill_cnt unchanged.
REQ-021 mode=01 SHALL set q <= {sin_msb, q[WIDTH-1:1]}.
REQ-022 mode=10 SHALL set q <= {q[WIDTH-2:0], sin_lsb}.
REQ-023 mode=11 SHALL set q <= d and fill_cnt <= WIDTH.
REQ-024 Each shift (mode 01 or 10) SHALL increment fill_cnt by 1, saturating at WIDTH with no wrap-around.
REQ-025 A change of shift direction SHALL NOT reset fill_cnt.
REQ-026 Latency SHALL be one clock: the result of an operation is visible on q immediately after the edge that samples it.
REQ-027 qb, sout_lsb, sout_msb and full SHALL be purely combinational from the registered q and fill_cnt, with no extra cycle of delay.
REQ-028 The serial outputs SHALL present the pre-edge value of the bit being shifted out, so that cascaded instances chain without a bubble.

Reset
REQ-029 reset=0 SHALL immediately, without a clock edge, force q=RESET_VAL, qb=~RESET_VAL and fill_cnt=0 (so full=0).
REQ-030 While reset=0 the block SHALL ignore all synchronous inputs.
REQ-031 Reset asserted mid-operation SHALL discard any in-progress fill count.
REQ-032 After reset deasserts, the first operation SHALL occur at the first rising edge at which reset=1.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-033 Scenario: assert reset=0 between clock edges -> q=00 and qb=FF immediately, fill_cnt=0, full=0.
REQ-034 Scenario: en=1, mode=11, d=A5, one edge -> q=A5, qb=5A, fill_cnt=8, full=1; then mode=01, sin_msb=1, one edge -> q=D2, with sout_lsb=1 before that edge.
REQ-035 Scenario: after reset, 9 edges of mode=10 with sin_lsb=1 -> fill_cnt steps 1..8 and saturates at 8, q=FF after edge 8, full rises on edge 8 and stays high.
REQ-036 Scenario: q=A5, then sclr=1 with mode=11 and d=3C in the same cycle -> q=00, fill_cnt=0; then en=0 with mode=11 for 3 edges -> q stays 00.
REQ-037 Scenario: RESET_VAL=3C, assert reset, then assert sclr -> q=3C and qb=C3 in both cases.
REQ-038 Scenario: two instances cascaded through sout_lsb into sin_msb, 16 right shifts of a serial pattern -> the concatenated q values equal the serial pattern with no lost or duplicated bit.
